mmio_io_responder: RTL and testbench

Memory-mapped peripheral responder on the core's data port, placed alongside the unified memory as the other end of the core's load/store interface. It decodes word addresses and honours per-byte write enables. It returns read data with the same one-cycle synchronous latency as the block RAM port. It owns the LED and seven-segment registers, a debounced switch input register, and a 64-bit timer with compare interrupt.

---
 rtl/mmio_io_responder.sv | 169 ++++++++++++++++
 tb/tb_mmio_io_responder.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_io_responder.sv
// rtl/mmio_io_responder.sv - MMIO responder: LED/7-seg/debounced switch registers, optional 64-bit timer.
// Optional timer/compare/CTRL/irq block is built only when MMIO_TIMER_EN is defined.
module mmio_io_responder #(
    parameter int unsigned PRESCALE        = 1,
    parameter int unsigned DEBOUNCE_CYCLES = 100000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        sel_i,
    input  logic [31:0] addr_i,
    input  logic [3:0]  we_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    input  logic [3:0]  sw_i,
    output logic [3:0]  led_o,
    output logic [3:0]  seven_seg_o,
    output logic        irq_o
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] DB_MAX = CW'(DEBOUNCE_CYCLES);

    logic [2:0]  reg_idx;
    logic        wr_en;

    logic [3:0]  led_q, led_d;
    logic [3:0]  seg_q, seg_d;
    logic [3:0]  switch_q;
    logic [3:0]  sw_meta_q, sw_sync_q, sw_last_q;
    logic [CW-1:0] db_cnt_q, db_cnt_d;
    logic [31:0] rdata_q, rdata_d;

    assign reg_idx = addr_i[4:2];
    assign wr_en   = sel_i & (|we_i);

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  be);
        logic [31:0] r;
        r = old_v;
        for (int k = 0; k < 4; k++) begin
            if (be[k]) r[8*k +: 8] = new_v[8*k +: 8];
        end
        return r;
    endfunction

    always_comb begin
        led_d = led_q;
        seg_d = seg_q;
        if (wr_en && we_i[0] && reg_idx == 3'd0) led_d = wdata_i[3:0];
        if (wr_en && we_i[0] && reg_idx == 3'd1) seg_d = wdata_i[3:0];
    end

    // The current sample counts as the first of a new run whenever it differs from the previous one.
    always_comb begin
        if (sw_sync_q != sw_last_q) begin
            db_cnt_d = CW'(1);
        end else if (db_cnt_q != DB_MAX) begin
            db_cnt_d = db_cnt_q + CW'(1);
        end else begin
            db_cnt_d = db_cnt_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            led_q     <= '0;
            seg_q     <= '0;
            switch_q  <= '0;
            sw_meta_q <= '0;
            sw_sync_q <= '0;
            sw_last_q <= '0;
            db_cnt_q  <= '0;
            rdata_q   <= '0;
        end else begin
            led_q     <= led_d;
            seg_q     <= seg_d;
            sw_meta_q <= sw_i;
            sw_sync_q <= sw_meta_q;
            sw_last_q <= sw_sync_q;
            db_cnt_q  <= db_cnt_d;
            if (db_cnt_d == DB_MAX) switch_q <= sw_sync_q;
            rdata_q   <= rdata_d;
        end
    end

`ifdef MMIO_TIMER_EN
    localparam logic [15:0] PRE_MAX = 16'(PRESCALE - 1);

    logic [15:0] pre_q, pre_d;
    logic [63:0] tmr_q, tmr_d;
    logic [63:0] cmp_q, cmp_d;
    logic        irq_en_q, irq_en_d;
    logic        pend_q, pend_d;
    logic        tick;
    logic        ctrl_wr;

    always_comb begin
        tick    = (pre_q == PRE_MAX);
        pre_d   = tick ? 16'd0 : pre_q + 16'd1;
        ctrl_wr = wr_en && we_i[0] && (reg_idx == 3'd7);
        tmr_d   = tmr_q;
        cmp_d   = cmp_q;
        // A timer write replaces the tick for that cycle; untouched bytes hold.
        if (wr_en && reg_idx == 3'd3) begin
            tmr_d[31:0] = merge_bytes(tmr_q[31:0], wdata_i, we_i);
        end else if (wr_en && reg_idx == 3'd4) begin
            tmr_d[63:32] = merge_bytes(tmr_q[63:32], wdata_i, we_i);
        end else if (tick) begin
            tmr_d = tmr_q + 64'd1;
        end
        if (wr_en && reg_idx == 3'd5) cmp_d[31:0]  = merge_bytes(cmp_q[31:0], wdata_i, we_i);
        if (wr_en && reg_idx == 3'd6) cmp_d[63:32] = merge_bytes(cmp_q[63:32], wdata_i, we_i);
        irq_en_d = ctrl_wr ? wdata_i[0] : irq_en_q;
        pend_d   = (irq_en_q && (tmr_q >= cmp_q)) | (pend_q & ~(ctrl_wr & wdata_i[1]));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pre_q    <= '0;
            tmr_q    <= '0;
            cmp_q    <= '1;
            irq_en_q <= 1'b0;
            pend_q   <= 1'b0;
        end else begin
            pre_q    <= pre_d;
            tmr_q    <= tmr_d;
            cmp_q    <= cmp_d;
            irq_en_q <= irq_en_d;
            pend_q   <= pend_d;
        end
    end

    assign irq_o = pend_q & irq_en_q;

    logic unused_bits;
    assign unused_bits = ^{addr_i[31:5], addr_i[1:0]};
`else
    assign irq_o = 1'b0;

    logic unused_bits;
    assign unused_bits = ^{addr_i[31:5], addr_i[1:0], wdata_i[31:4], 16'(PRESCALE)};
`endif

    // Reads see pre-write state; an unselected cycle returns 0 for OR-combining.
    always_comb begin
        rdata_d = '0;
        if (sel_i) begin
            case (reg_idx)
                3'd0: rdata_d = {28'd0, led_q};
                3'd1: rdata_d = {28'd0, seg_q};
                3'd2: rdata_d = {28'd0, switch_q};
`ifdef MMIO_TIMER_EN
                3'd3: rdata_d = tmr_q[31:0];
                3'd4: rdata_d = tmr_q[63:32];
                3'd5: rdata_d = cmp_q[31:0];
                3'd6: rdata_d = cmp_q[63:32];
                3'd7: rdata_d = {30'd0, pend_q, irq_en_q};
`endif
                default: rdata_d = '0;
            endcase
        end
    end

    assign rdata_o     = rdata_q;
    assign led_o       = led_q;
    assign seven_seg_o = seg_q;

endmodule

// File: tb/tb_mmio_io_responder.sv
// tb/tb_mmio_io_responder.sv - self-checking bench for mmio_io_responder (honours MMIO_TIMER_EN).
module tb_mmio_io_responder;

    localparam int TB_PRESCALE = 1;
    localparam int DB          = 4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        sel_i;
    logic [31:0] addr_i;
    logic [3:0]  we_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_o;
    logic [3:0]  sw_i;
    logic [3:0]  led_o;
    logic [3:0]  seven_seg_o;
    logic        irq_o;

    int total = 0;
    int bad   = 0;

    mmio_io_responder #(.PRESCALE(TB_PRESCALE), .DEBOUNCE_CYCLES(DB)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .sel_i(sel_i), .addr_i(addr_i), .we_i(we_i),
        .wdata_i(wdata_i), .rdata_o(rdata_o), .sw_i(sw_i), .led_o(led_o),
        .seven_seg_o(seven_seg_o), .irq_o(irq_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: register contents plus a window over recent switch samples.
    logic [3:0] m_led, m_seg, m_sw;
    logic [3:0] hist[$];
`ifdef MMIO_TIMER_EN
    logic [63:0] m_tmr, m_cmp;
    logic        m_en, m_pend;
    int          m_pre;
`endif

    typedef struct {
        logic        sel;
        logic [31:0] addr;
        logic [3:0]  we;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic [3:0]  exp_led;
        logic [3:0]  exp_seg;
    } vec_t;

    vec_t tbl[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int k = 0; k < 4; k++) if (be[k]) r[8*k +: 8] = n[8*k +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_read(input logic [2:0] idx);
        case (idx)
            3'd0: return {28'd0, m_led};
            3'd1: return {28'd0, m_seg};
            3'd2: return {28'd0, m_sw};
`ifdef MMIO_TIMER_EN
            3'd3: return m_tmr[31:0];
            3'd4: return m_tmr[63:32];
            3'd5: return m_cmp[31:0];
            3'd6: return m_cmp[63:32];
            3'd7: return {30'd0, m_pend, m_en};
`endif
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_led = 0; m_seg = 0; m_sw = 0;
        hist.delete();
        for (int i = 0; i < DB + 2; i++) hist.push_back(4'd0);
`ifdef MMIO_TIMER_EN
        m_tmr = 0; m_cmp = '1; m_en = 0; m_pend = 0; m_pre = 0;
`endif
    endtask

    // Drive one access for one clock, advance the model, compare every output.
    task automatic step(input logic s, input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
        logic [2:0]  idx;
        logic [31:0] exp_r;
        logic        wr;
        logic        ok;
        logic [3:0]  v;
        logic        exp_irq;
        int          n;
        sel_i = s; addr_i = a; we_i = w; wdata_i = d;
        idx   = a[4:2];
        exp_r = s ? m_read(idx) : 32'd0;
        wr    = s && (w != 4'd0);
        if (wr && w[0] && idx == 3'd0) m_led = d[3:0];
        if (wr && w[0] && idx == 3'd1) m_seg = d[3:0];
`ifdef MMIO_TIMER_EN
        begin
            logic set, clr;
            set = m_en && (m_tmr >= m_cmp);
            clr = wr && w[0] && idx == 3'd7 && d[1];
            m_pend = set || (m_pend && !clr);
            if (wr && w[0] && idx == 3'd7) m_en = d[0];
            if (wr && idx == 3'd3)      m_tmr[31:0]  = merge(m_tmr[31:0], d, w);
            else if (wr && idx == 3'd4) m_tmr[63:32] = merge(m_tmr[63:32], d, w);
            else if (m_pre == TB_PRESCALE - 1) m_tmr = m_tmr + 64'd1;
            m_pre = (m_pre + 1) % TB_PRESCALE;
            if (wr && idx == 3'd5) m_cmp[31:0]  = merge(m_cmp[31:0], d, w);
            if (wr && idx == 3'd6) m_cmp[63:32] = merge(m_cmp[63:32], d, w);
        end
        exp_irq = m_pend && m_en;
`else
        exp_irq = 1'b0;
`endif
        hist.push_back(sw_i);
        n  = hist.size();
        v  = hist[n-3];
        ok = 1'b1;
        for (int k = 3; k <= DB + 2; k++) if (hist[n-k] != v) ok = 1'b0;
        if (ok) m_sw = v;
        if (n > DB + 6) void'(hist.pop_front());
        @(posedge clk_i);
        #1;
        check("rdata", rdata_o, exp_r);
        check("led", led_o, m_led);
        check("seg", seven_seg_o, m_seg);
        check("irq", irq_o, exp_irq);
    endtask

    initial begin
        int first_a;
        int n;
        rst_i = 1'b1; sel_i = 0; addr_i = 0; we_i = 0; wdata_i = 0; sw_i = 0;
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_rdata", rdata_o, 0);
        check("rst_led", led_o, 0);
        check("rst_seg", seven_seg_o, 0);
        check("rst_irq", irq_o, 0);
        rst_i = 1'b0;
        model_reset();

        tbl[0]  = '{1'b1, 32'h00, 4'b0001, 32'h0000_00A5, 32'h0, 4'h5, 4'h0};
        tbl[1]  = '{1'b1, 32'h00, 4'b0000, 32'h0,         32'h5, 4'h5, 4'h0};
        tbl[2]  = '{1'b1, 32'h00, 4'b0010, 32'h0000_00A5, 32'h5, 4'h5, 4'h0};
        tbl[3]  = '{1'b1, 32'h04, 4'b1111, 32'hFFFF_FFF9, 32'h0, 4'h5, 4'h9};
        tbl[4]  = '{1'b1, 32'h04, 4'b0000, 32'h0,         32'h9, 4'h5, 4'h9};
        tbl[5]  = '{1'b0, 32'h04, 4'b0000, 32'h0,         32'h0, 4'h5, 4'h9};
        tbl[6]  = '{1'b0, 32'h00, 4'b0001, 32'h3,         32'h0, 4'h5, 4'h9};
        tbl[7]  = '{1'b1, 32'h08, 4'b1111, 32'hF,         32'h0, 4'h5, 4'h9};
        tbl[8]  = '{1'b1, 32'h20, 4'b0000, 32'h0,         32'h5, 4'h5, 4'h9};
        tbl[9]  = '{1'b1, 32'h01, 4'b0001, 32'hC,         32'h5, 4'hC, 4'h9};
        tbl[10] = '{1'b1, 32'h00, 4'b0000, 32'h0,         32'hC, 4'hC, 4'h9};
        for (int i = 0; i < 11; i++) begin
            step(tbl[i].sel, tbl[i].addr, tbl[i].we, tbl[i].wdata);
            check($sformatf("tbl%0d_rdata", i), rdata_o, tbl[i].exp_rdata);
            check($sformatf("tbl%0d_led", i), led_o, tbl[i].exp_led);
            check($sformatf("tbl%0d_seg", i), seven_seg_o, tbl[i].exp_seg);
        end

        // Glitch to 0x3 for two cycles, then settle on 0xA.
        sw_i = 4'h3;
        repeat (2) begin
            step(1'b1, 32'h08, 4'd0, 32'd0);
            check("sw_glitch", rdata_o == 32'h3, 0);
        end
        sw_i = 4'hA;
        first_a = 0;
        for (int i = 1; i <= 12; i++) begin
            step(1'b1, 32'h08, 4'd0, 32'd0);
            check("sw_no_glitch", rdata_o == 32'h3, 0);
            if (first_a == 0 && rdata_o == 32'hA) first_a = i;
        end
        check("sw_latency", first_a, DB + 3);
        check("sw_final", rdata_o, 32'hA);

`ifdef MMIO_TIMER_EN
        step(1'b1, 32'h0C, 4'hF, 32'hFFFF_FFFE);
        step(1'b1, 32'h10, 4'hF, 32'h0);
        step(1'b0, 32'h0, 4'd0, 32'd0);
        step(1'b0, 32'h0, 4'd0, 32'd0);
        step(1'b1, 32'h0C, 4'd0, 32'd0);
        check("tmr_lo_carry", rdata_o, 32'h0);
        step(1'b1, 32'h10, 4'd0, 32'd0);
        check("tmr_hi_carry", rdata_o, 32'h1);

        step(1'b1, 32'h14, 4'hF, 32'd20);
        step(1'b1, 32'h18, 4'hF, 32'd0);
        step(1'b1, 32'h10, 4'hF, 32'd0);
        step(1'b1, 32'h0C, 4'hF, 32'd0);
        step(1'b1, 32'h1C, 4'h1, 32'd1);
        n = 0;
        do begin
            step(1'b0, 32'h0, 4'd0, 32'd0);
            n++;
        end while (!irq_o && n < 60);
        check("irq_latency", n, 20);
        step(1'b1, 32'h1C, 4'h1, 32'd3);
        check("irq_set_wins", irq_o, 1);
        step(1'b1, 32'h14, 4'hF, 32'hFFFF_FFFF);
        step(1'b1, 32'h18, 4'hF, 32'hFFFF_FFFF);
        step(1'b1, 32'h1C, 4'h1, 32'd3);
        check("irq_cleared", irq_o, 0);
`else
        step(1'b1, 32'h1C, 4'hF, 32'hFFFF_FFFF);
        step(1'b1, 32'h1C, 4'd0, 32'd0);
        check("ctrl_absent", rdata_o, 32'h0);
        check("irq_absent", irq_o, 0);
        step(1'b1, 32'h0C, 4'hF, 32'hFFFF_FFFF);
        step(1'b1, 32'h0C, 4'd0, 32'd0);
        check("timer_absent", rdata_o, 32'h0);
`endif

        for (int i = 0; i < 1500; i++) begin
            logic        s;
            logic [3:0]  w;
            if ($urandom_range(7) == 0) sw_i = 4'($urandom_range(15));
            s = ($urandom_range(3) != 0);
            w = ($urandom_range(1) == 0) ? 4'd0 : 4'($urandom_range(15));
            step(s, $urandom, w, $urandom);
        end

        // Asynchronous reset in the middle of a read.
        step(1'b1, 32'h00, 4'h1, 32'hF);
        step(1'b1, 32'h00, 4'h0, 32'h0);
        check("pre_rst_rdata", rdata_o, 32'hF);
        sel_i = 1'b1; addr_i = 32'h0; we_i = 4'h1; wdata_i = 32'h7;
        #3;
        rst_i = 1'b1;
        #1;
        check("arst_rdata", rdata_o, 0);
        check("arst_led", led_o, 0);
        check("arst_seg", seven_seg_o, 0);
        check("arst_irq", irq_o, 0);
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        step(1'b1, 32'h00, 4'h0, 32'h0);
        check("post_rst_led_read", rdata_o, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
